// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//
// Multi-cycle multiply/divide sequencer that owns the MIPS HI/LO register pair.
// MULT/MULTU/DIV/DIVU are started from EX. The 64-bit result is computed when
// the operation is accepted and parked in holding registers. It is committed
// to HI/LO after MUL_CYCLES or DIV_CYCLES busy cycles. MTHI/MTLO write HI/LO
// directly at the accepting edge and never go busy.
//
// Handshake: an operation is accepted on a rising edge where md_valid=1, the
// unit is IDLE and (with MD_FLUSH_EN) flush=0. While busy=1 every md_valid is
// dropped. The pipeline must stall HI/LO users rather than rely on any
// queueing. done pulses for the one cycle in which the committed HI/LO are
// first visible.
//
// Optional feature macro: MD_FLUSH_EN
//   defined   : flush=1 aborts a BUSY operation (HI/LO untouched, no done).
//               In IDLE it also blocks the start or MTHI/MTLO sampled in that
//               cycle.
//   undefined : flush is ignored.
//
// Parameters:
//   MUL_CYCLES  busy cycles for MULT/MULTU (1..63)
//   DIV_CYCLES  busy cycles for DIV/DIVU   (1..63)
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   md_op     in   [2:0] 0 none,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO,7 none
//   md_valid  in   EX holds a valid md instruction
//   flush     in   cancel in-flight / blocked start (MD_FLUSH_EN only)
//   rs_data   in   [31:0] operand A / MTHI-MTLO source
//   rt_data   in   [31:0] operand B
//   hi        out  [31:0] HI register
//   lo        out  [31:0] LO register
//   busy      out  operation in flight (registered)
//   done      out  one-cycle pulse when new HI/LO first visible (registered)
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  md_op,
    input  logic        md_valid,
    input  logic        flush,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [5:0] MUL_CNT = 6'(MUL_CYCLES);
    localparam logic [5:0] DIV_CNT = 6'(DIV_CYCLES);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] res_hi_q, res_hi_d;
    logic [31:0] res_lo_q, res_lo_d;
    logic        done_q, done_d;

    // Flush qualifier: tied off when the feature is compiled out.
    logic flush_act;
`ifdef MD_FLUSH_EN
    assign flush_act = flush;
`else
    logic flush_unused;
    assign flush_unused = flush;
    assign flush_act    = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // Arithmetic datapath (evaluated on the operands presented in IDLE)
    // ---------------------------------------------------------------------
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic               div_zero;
    logic               div_ovf;
    logic        [31:0] divs_b;
    logic        [31:0] divu_b;
    logic signed [31:0] quo_s, rem_s;
    logic        [31:0] quo_u, rem_u;

    assign prod_s = $signed({{32{rs_data[31]}}, rs_data}) *
                    $signed({{32{rt_data[31]}}, rt_data});
    assign prod_u = {32'd0, rs_data} * {32'd0, rt_data};

    assign div_zero = (rt_data == 32'd0);
    assign div_ovf  = (rs_data == 32'h8000_0000) && (rt_data == 32'hFFFF_FFFF);

    // The special cases are overridden below. A divisor of 1 keeps the
    // dividers away from /0 and the signed overflow corner. The unsigned
    // divider must not see the signed overflow substitution.
    assign divs_b = (div_zero || div_ovf) ? 32'd1 : rt_data;
    assign divu_b = div_zero ? 32'd1 : rt_data;

    // Verilog signed / truncates toward zero and % follows the dividend sign,
    // which matches MIPS DIV semantics directly.
    assign quo_s = $signed(rs_data) / $signed(divs_b);
    assign rem_s = $signed(rs_data) % $signed(divs_b);
    assign quo_u = rs_data / divu_b;
    assign rem_u = rs_data % divu_b;

    logic        start_arith;
    logic [63:0] start_res;
    logic [5:0]  start_cnt;

    always_comb begin
        start_arith = 1'b0;
        start_res   = '0;
        start_cnt   = '0;
        case (md_op)
            OP_MULT: begin
                start_arith = 1'b1;
                start_res   = prod_s;
                start_cnt   = MUL_CNT;
            end
            OP_MULTU: begin
                start_arith = 1'b1;
                start_res   = prod_u;
                start_cnt   = MUL_CNT;
            end
            OP_DIV: begin
                start_arith = 1'b1;
                start_cnt   = DIV_CNT;
                if (div_zero)
                    start_res = {rs_data, 32'hFFFF_FFFF};
                else if (div_ovf)
                    start_res = {32'h0000_0000, 32'h8000_0000};
                else
                    start_res = {rem_s, quo_s};
            end
            OP_DIVU: begin
                start_arith = 1'b1;
                start_cnt   = DIV_CNT;
                if (div_zero)
                    start_res = {rs_data, 32'hFFFF_FFFF};
                else
                    start_res = {rem_u, quo_u};
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------------
    // Sequencer: next state
    // ---------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (md_valid && !flush_act) begin
                    if (start_arith) begin
                        res_hi_d = start_res[63:32];
                        res_lo_d = start_res[31:0];
                        cnt_d    = start_cnt;
                        state_d  = ST_BUSY;
                    end else if (md_op == OP_MTHI) begin
                        hi_d = rs_data;
                    end else if (md_op == OP_MTLO) begin
                        lo_d = rs_data;
                    end
                end
            end
            ST_BUSY: begin
                if (flush_act) begin
                    // Abort: the held result is simply never committed.
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (cnt_q == 6'd1) begin
                    hi_d    = res_hi_q;
                    lo_d    = res_lo_q;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Sequencer: state registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            done_q   <= done_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state_q == ST_BUSY);
    assign done = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//
// Bench for muldiv_unit. Inputs are driven on the falling edge and outputs are
// sampled on the falling edge. Each arithmetic start pushes its expected
// {hi,lo} onto exp_q. The monitor pops the queue on every done pulse and
// compares. Scenario tasks check busy length, done pulse width, MT timing,
// busy protection, reset and flush inline.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_RSVD  = 3'd7;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  md_op = OP_NONE;
    logic        md_valid = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic [31:0] hi, lo;
    logic        busy, done;

    always #5 clk = ~clk;

    muldiv_unit #(
        .MUL_CYCLES(MUL_N),
        .DIV_CYCLES(DIV_N)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .md_op   (md_op),
        .md_valid(md_valid),
        .flush   (flush),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .done    (done)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- scoreboard ----------------
    logic [63:0] exp_q[$];
    logic [63:0] sb_exp;

    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_done: hi=%h lo=%h, no result was pending", hi, lo);
            end else begin
                sb_exp = exp_q.pop_front();
                if ({hi, lo} !== sb_exp) begin
                    errors++;
                    $display("FAIL sb_result: hi_lo=%h expected %h", {hi, lo}, sb_exp);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] ua, ub, q, r;
        model = '0;
        case (op)
            OP_MULT:  model = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            OP_MULTU: model = {32'd0, a} * {32'd0, b};
            OP_DIV: begin
                if (b == 32'd0) model = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = {32'd0, 32'h8000_0000};
                else begin
                    ua = a[31] ? -a : a;
                    ub = b[31] ? -b : b;
                    q  = ua / ub;
                    r  = ua % ub;
                    if (a[31] ^ b[31]) q = -q;
                    if (a[31]) r = -r;
                    model = {r, q};
                end
            end
            OP_DIVU: begin
                if (b == 32'd0) model = {a, 32'hFFFF_FFFF};
                else model = {a % b, a / b};
            end
            default: model = '0;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    // Presents one op for one rising edge and returns at the falling edge
    // after it, with md_valid dropped. now=1 drives at the current falling edge.
    task automatic drive_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input bit now);
        if (!now) @(negedge clk);
        md_valid = 1'b1;
        md_op    = op;
        rs_data  = a;
        rt_data  = b;
        @(posedge clk);
        @(negedge clk);
        md_valid = 1'b0;
        md_op    = OP_NONE;
    endtask

    // Counts falling edges with busy=1 until done is seen (bounded).
    task automatic wait_done(output int nbusy, output bit got);
        nbusy = 0;
        got   = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (busy === 1'b1) nbusy++;
            @(negedge clk);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bit seen;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b, expected all zero", hi, lo, busy, done);
        end
        rst = 1'b0;
        drive_op(OP_MTHI, 32'h55, 32'd0, 1'b0);
        drive_op(OP_MTLO, 32'hAA, 32'd0, 1'b0);
        checks++;
        if (hi !== 32'h55 || lo !== 32'hAA) begin
            errors++;
            $display("FAIL reset_preload: hi=%h lo=%h, expected 55 aa", hi, lo);
        end
        exp_q.push_back(model(OP_DIV, 32'hFFFF_FFF9, 32'd2));
        drive_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: hi=%h lo=%h busy=%b done=%b, expected all zero", hi, lo, busy, done);
        end
        exp_q.delete();
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen || hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL reset_discard: activity=%b hi=%h lo=%h, expected no busy/done, hi=lo=0", seen, hi, lo);
        end
    endtask

    task automatic test_mult();
        logic [2:0]  op  [2] = '{OP_MULT, OP_MULTU};
        logic [63:0] exp [2] = '{64'hFFFF_FFFF_FFFF_FFFA, 64'h0000_0002_FFFF_FFFA};
        int nb;
        bit got;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(exp[i]);
            drive_op(op[i], 32'hFFFF_FFFE, 32'd3, 1'b0);
            wait_done(nb, got);
            checks++;
            if (!got || nb != MUL_N || busy !== 1'b0) begin
                errors++;
                $display("FAIL mult_busy_len[%0d]: busy %0d cycles, done=%0b busy_at_done=%b; expected %0d then done",
                         i, nb, got, busy, MUL_N);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL mult_done_pulse[%0d]: done=%b busy=%b, expected 0 0", i, done, busy);
            end
        end
    endtask

    task automatic test_div();
        logic [2:0]  op  [7] = '{OP_DIV, OP_DIVU, OP_DIV, OP_DIV, OP_DIV, OP_DIVU, OP_DIVU};
        logic [31:0] a   [7] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'hFFFF_FFFB, 32'd7,
                                 32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] b   [7] = '{32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFE, 32'd10,
                                 32'hFFFF_FFFF};
        logic [63:0] exp [7] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0007_FFFF_FFFF,
                                 64'h0000_0000_8000_0000, 64'hFFFF_FFFB_FFFF_FFFF,
                                 64'h0000_0001_FFFF_FFFD, 64'h0000_0005_1999_9999,
                                 64'h8000_0000_0000_0000};
        int nb;
        bit got;
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(exp[i]);
            drive_op(op[i], a[i], b[i], 1'b0);
            wait_done(nb, got);
            checks++;
            if (!got || nb != DIV_N || busy !== 1'b0) begin
                errors++;
                $display("FAIL div_busy_len[%0d]: busy %0d cycles, done=%0b busy_at_done=%b; expected %0d then done",
                         i, nb, got, busy, DIV_N);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL div_done_pulse[%0d]: done=%b, expected 0", i, done);
            end
        end
    endtask

    task automatic test_mt();
        logic [31:0] h0, l0;
        drive_op(OP_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b0);
        checks++;
        if (hi !== 32'hDEAD_BEEF || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mthi: hi=%h busy=%b done=%b, expected deadbeef 0 0", hi, busy, done);
        end
        drive_op(OP_MTLO, 32'h1234_5678, 32'd0, 1'b0);
        checks++;
        if (lo !== 32'h1234_5678 || hi !== 32'hDEAD_BEEF || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mtlo: hi=%h lo=%h busy=%b done=%b, expected deadbeef 12345678 0 0", hi, lo, busy, done);
        end
        h0 = hi;
        l0 = lo;
        drive_op(OP_NONE, 32'h1, 32'h2, 1'b0);
        drive_op(OP_RSVD, 32'h3, 32'h4, 1'b0);
        @(negedge clk);
        md_op   = OP_MULT;   // presented without md_valid: must be ignored
        rs_data = 32'h9;
        @(posedge clk);
        @(negedge clk);
        md_op = OP_NONE;
        checks++;
        if (hi !== h0 || lo !== l0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL noop_ops: hi=%h lo=%h busy=%b done=%b, expected %h %h 0 0", hi, lo, busy, done, h0, l0);
        end
    endtask

    task automatic test_busy_protect();
        logic [31:0] l0;
        int nb;
        bit got, seen;
        exp_q.push_back(64'h0000_0000_0000_0006);
        drive_op(OP_MULTU, 32'd2, 32'd3, 1'b0);
        l0 = lo;
        drive_op(OP_MTLO, 32'h1234, 32'd0, 1'b1);
        drive_op(OP_DIVU, 32'd100, 32'd7, 1'b1);
        checks++;
        if (busy !== 1'b1 || lo !== l0) begin
            errors++;
            $display("FAIL protect_during_busy: busy=%b lo=%h, expected 1 %h", busy, lo, l0);
        end
        wait_done(nb, got);
        checks++;
        if (!got || nb != MUL_N - 2) begin
            errors++;
            $display("FAIL protect_busy_len: remaining busy %0d, done=%0b; expected %0d then done", nb, got, MUL_N - 2);
        end
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (busy === 1'b1 || done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen || lo !== 32'd6 || hi !== 32'd0) begin
            errors++;
            $display("FAIL protect_ignored: later activity=%b hi=%h lo=%h, expected none 0 6", seen, hi, lo);
        end
    endtask

    task automatic test_back_to_back();
        int nb;
        bit got;
        exp_q.push_back(64'h0000_0000_0000_0200);
        drive_op(OP_MULT, 32'h10, 32'h20, 1'b0);
        wait_done(nb, got);
        checks++;
        if (!got || nb != MUL_N) begin
            errors++;
            $display("FAIL b2b_first: busy %0d cycles, done=%0b; expected %0d then done", nb, got, MUL_N);
        end
        // Start the next op in the done cycle itself.
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFF9);
        drive_op(OP_MULT, 32'hFFFF_FFFF, 32'd7, 1'b1);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: busy=%b done=%b after start in done cycle, expected 1 0", busy, done);
        end
        wait_done(nb, got);
        checks++;
        if (!got || nb != MUL_N) begin
            errors++;
            $display("FAIL b2b_second: busy %0d cycles, done=%0b; expected %0d then done", nb, got, MUL_N);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b;
        int nb, n;
        bit got;
        for (int i = 0; i < 16; i++) begin
            op = 3'($urandom_range(1, 4));
            a  = $urandom();
            b  = $urandom();
            if ($urandom_range(0, 5) == 0) b = 32'd0;
            else if ($urandom_range(0, 2) == 0) b = 32'($urandom_range(1, 9));
            n = (op == OP_MULT || op == OP_MULTU) ? MUL_N : DIV_N;
            exp_q.push_back(model(op, a, b));
            drive_op(op, a, b, 1'b0);
            wait_done(nb, got);
            checks++;
            if (!got || nb != n) begin
                errors++;
                $display("FAIL random_busy_len[%0d]: op=%0d busy %0d, done=%0b; expected %0d then done",
                         i, op, nb, got, n);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_flush();
        logic [31:0] h0, l0;
        int nb;
        bit got, seen;
        h0 = hi;
        l0 = lo;
        exp_q.push_back(64'h0000_0002_0000_000E);   // 100 / 7
        drive_op(OP_DIV, 32'd100, 32'd7, 1'b0);
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;                               // third busy cycle
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
`ifdef MD_FLUSH_EN
        void'(exp_q.pop_back());
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== h0 || lo !== l0) begin
            errors++;
            $display("FAIL flush_abort: busy=%b done=%b hi=%h lo=%h, expected 0 0 %h %h", busy, done, hi, lo, h0, l0);
        end
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen || hi !== h0 || lo !== l0) begin
            errors++;
            $display("FAIL flush_no_done: activity=%b hi=%h lo=%h, expected none %h %h", seen, hi, lo, h0, l0);
        end
        flush = 1'b1;
        drive_op(OP_MTHI, 32'hCAFE_F00D, 32'd0, 1'b0);
        flush = 1'b0;
        checks++;
        if (hi !== h0) begin
            errors++;
            $display("FAIL flush_idle_block: hi=%h, expected %h", hi, h0);
        end
`else
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL flush_ignored: busy=%b after flush, expected 1", busy);
        end
        wait_done(nb, got);
        checks++;
        if (!got || nb != DIV_N - 3) begin
            errors++;
            $display("FAIL flush_ignored_len: remaining busy %0d, done=%0b; expected %0d then done", nb, got, DIV_N - 3);
        end
        @(negedge clk);
        flush = 1'b1;
        drive_op(OP_MTHI, 32'hCAFE_F00D, 32'd0, 1'b1);
        flush = 1'b0;
        checks++;
        if (hi !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL flush_idle_ignored: hi=%h, expected cafef00d", hi);
        end
        seen = (h0 == l0);   // keep both captures referenced in this build
`endif
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mt();
        test_busy_protect();
        test_back_to_back();
        test_random();
        test_flush();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d results never delivered, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
